// File: rtl/crc_check_window_timer.sv
// Per-channel check-enable window timer for the CRC-7 receive path.
// Each channel holds en_check for a programmable window after the last en_data strobe, then flags a timeout.
module crc_check_window_timer #(
    parameter int unsigned CH       = 4,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned ONE_SHOT = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [CH-1:0]    en_data,
    input  logic [CNT_W-1:0] win_len,
    input  logic             hold,
    input  logic [CH-1:0]    clr_flag,
    output logic [CH-1:0]    en_check,
    output logic [CH-1:0]    timeout,
    output logic [CH-1:0]    timeout_flag,
    output logic             any_timeout
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    state_e           state_q [CH];
    state_e           state_d [CH];
    logic [CNT_W-1:0] rem_q   [CH];
    logic [CNT_W-1:0] rem_d   [CH];
    logic [CH-1:0]    timeout_q, timeout_d;
    logic [CH-1:0]    flag_q, flag_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < CH; i++) begin
                state_q[i] <= IDLE;
                rem_q[i]   <= '0;
            end
            timeout_q <= '0;
            flag_q    <= '0;
        end else begin
            for (int unsigned i = 0; i < CH; i++) begin
                state_q[i] <= state_d[i];
                rem_q[i]   <= rem_d[i];
            end
            timeout_q <= timeout_d;
            flag_q    <= flag_d;
        end
    end

    // Open/restart takes priority over both hold and expiry on the same edge.
    always_comb begin
        timeout_d = '0;
        flag_d    = flag_q;
        for (int unsigned i = 0; i < CH; i++) begin
            state_d[i] = state_q[i];
            rem_d[i]   = rem_q[i];
            if (en_data[i] && (state_q[i] == IDLE || ONE_SHOT == 0)) begin
                state_d[i] = ACTIVE;
                rem_d[i]   = win_len - CNT_W'(1);
            end else if (state_q[i] == ACTIVE && !hold) begin
                if (rem_q[i] != '0) begin
                    rem_d[i] = rem_q[i] - CNT_W'(1);
                end else begin
                    state_d[i]   = IDLE;
                    timeout_d[i] = 1'b1;
                end
            end
            // Set beats clear when both land on the same edge.
            if (timeout_d[i]) begin
                flag_d[i] = 1'b1;
            end else if (clr_flag[i]) begin
                flag_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        en_check = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            en_check[i] = (state_q[i] == ACTIVE);
        end
    end

    assign timeout      = timeout_q;
    assign timeout_flag = flag_q;
    assign any_timeout  = |flag_q;

endmodule

// File: tb/tb_crc_check_window_timer.sv
// Directed bench: a retrigger-mode instance (a) and a one-shot instance (b) on a shared clock/reset.
module tb_crc_check_window_timer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] en_a, clr_a, chk_a, to_a, flg_a;
    logic [3:0] en_b, clr_b, chk_b, to_b, flg_b;
    logic [3:0] wl_a, wl_b;
    logic       hold_a, hold_b, any_a, any_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    crc_check_window_timer #(.CH(4), .CNT_W(4), .ONE_SHOT(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .en_data(en_a), .win_len(wl_a), .hold(hold_a),
        .clr_flag(clr_a), .en_check(chk_a), .timeout(to_a), .timeout_flag(flg_a),
        .any_timeout(any_a)
    );

    crc_check_window_timer #(.CH(4), .CNT_W(4), .ONE_SHOT(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .en_data(en_b), .win_len(wl_b), .hold(hold_b),
        .clr_flag(clr_b), .en_check(chk_b), .timeout(to_b), .timeout_flag(flg_b),
        .any_timeout(any_b)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        en_a = '0; clr_a = '0; wl_a = '0; hold_a = 1'b0;
        en_b = '0; clr_b = '0; wl_b = '0; hold_b = 1'b0;

        // Reset then idle
        repeat (3) @(posedge clk);
        #1;
        chk("reset_a", {3'b0, chk_a, to_a, flg_a, any_a}, 16'h0);
        chk("reset_b", {3'b0, chk_b, to_b, flg_b, any_b}, 16'h0);
        #2 reset_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            chk("idle_a", {3'b0, chk_a, to_a, flg_a, any_a}, 16'h0);
            chk("idle_b", {3'b0, chk_b, to_b, flg_b, any_b}, 16'h0);
        end

        // Default window: 16 cycles on channel 0
        wl_a = 4'd0; en_a = 4'b0001;
        step();
        en_a = '0;
        chk("def_open", {12'b0, chk_a}, 16'h1);
        for (int k = 1; k <= 15; k++) begin
            step();
            chk("def_active", {8'b0, chk_a, to_a}, {8'b0, 4'b0001, 4'b0000});
        end
        step();
        chk("def_expire", {3'b0, chk_a, to_a, flg_a, any_a}, {3'b0, 4'b0000, 4'b0001, 4'b0001, 1'b1});
        step();
        chk("def_after", {3'b0, chk_a, to_a, flg_a, any_a}, {3'b0, 4'b0000, 4'b0000, 4'b0001, 1'b1});

        // Retrigger on the expiry edge of channel 1
        wl_a = 4'd5; en_a = 4'b0010;
        step();
        en_a = '0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("rt_first", {8'b0, chk_a, to_a}, {8'b0, 4'b0010, 4'b0000});
        end
        en_a = 4'b0010;
        step();
        en_a = '0;
        chk("rt_tie", {8'b0, chk_a, to_a}, {8'b0, 4'b0010, 4'b0000});
        for (int k = 6; k <= 9; k++) begin
            step();
            chk("rt_second", {8'b0, chk_a, to_a}, {8'b0, 4'b0010, 4'b0000});
        end
        step();
        chk("rt_expire", {4'b0, chk_a, to_a, flg_a}, {4'b0, 4'b0000, 4'b0010, 4'b0011});

        // Clear existing flags
        clr_a = 4'b0011;
        step();
        clr_a = '0;
        chk("clr_flags", {11'b0, flg_a, any_a}, 16'h0);

        // Clear racing an expiry on channel 3 (win_len 2)
        wl_a = 4'd2; en_a = 4'b1000;
        step();
        en_a = '0;
        step();
        chk("race_active", {12'b0, chk_a}, 16'h8);
        clr_a = 4'b1000;
        step();
        chk("race_set_wins", {3'b0, chk_a, to_a, flg_a, any_a}, {3'b0, 4'b0000, 4'b1000, 4'b1000, 1'b1});
        step();
        clr_a = '0;
        chk("race_cleared", {7'b0, to_a, flg_a, any_a}, 16'h0);

        // One-shot with hold on channel 2 of dut_b (win_len 3)
        wl_b = 4'd3; en_b = 4'b0100;
        step();
        chk("os_open", {12'b0, chk_b}, 16'h4);
        hold_b = 1'b1;
        step();
        chk("os_hold1", {8'b0, chk_b, to_b}, {8'b0, 4'b0100, 4'b0000});
        step();
        chk("os_hold2", {8'b0, chk_b, to_b}, {8'b0, 4'b0100, 4'b0000});
        hold_b = 1'b0;
        step();
        en_b = '0;
        chk("os_e3", {8'b0, chk_b, to_b}, {8'b0, 4'b0100, 4'b0000});
        step();
        chk("os_e4", {8'b0, chk_b, to_b}, {8'b0, 4'b0100, 4'b0000});
        step();
        chk("os_expire", {4'b0, chk_b, to_b, flg_b}, {4'b0, 4'b0000, 4'b0100, 4'b0100});
        en_b = 4'b0100;
        step();
        en_b = '0;
        chk("os_reopen", {8'b0, chk_b, to_b}, {8'b0, 4'b0100, 4'b0000});
        step();
        step();
        chk("os_re_active", {8'b0, chk_b, to_b}, {8'b0, 4'b0100, 4'b0000});
        step();
        chk("os_re_expire", {8'b0, chk_b, to_b}, {8'b0, 4'b0000, 4'b0100});

        // Asynchronous reset mid-window
        wl_a = 4'd0; en_a = 4'b1111;
        step();
        en_a = '0;
        step();
        chk("ar_all_active", {12'b0, chk_a}, 16'hF);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_immediate_a", {3'b0, chk_a, to_a, flg_a, any_a}, 16'h0);
        chk("ar_immediate_b", {3'b0, chk_b, to_b, flg_b, any_b}, 16'h0);
        step();
        #2 reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("ar_quiet_a", {3'b0, chk_a, to_a, flg_a, any_a}, 16'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
